// File: rtl/gp_byte_serializer.sv
// -----------------------------------------------------------------------------
// gp_byte_serializer
//
// Purpose:
//   This is the downstream stage of the grasspopper encoder. The encoder
//   pipeline cannot stall, so every 128-bit ciphertext block it flags valid is
//   captured into a small block FIFO. The head block is then loaded into a
//   128-bit shift register and streamed out one byte at a time, most
//   significant byte first. The byte stream uses a valid/ready handshake and
//   feeds the UART/host readout path.
//
//   If a block arrives while the FIFO is full and no pop happens in the same
//   cycle, that block is dropped. A sticky flag then records the loss.
//
// Parameters:
//   FIFO_DEPTH    block FIFO entries (power of two, >= 2)
//   CNT_W         width of fifo_count_o (derived, not overridable)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-low reset
//   blk_valid_i   blk_data_i carries a ciphertext block this cycle
//   blk_data_i    128-bit ciphertext block
//   byte_o        current output byte (shreg[127:120])
//   byte_valid_o  byte_o is valid
//   byte_ready_i  consumer accepts byte_o when byte_valid_o && byte_ready_i
//   byte_last_o   byte_o is byte 15 of its block
//   fifo_count_o  blocks waiting in the FIFO (block in the shifter excluded)
//   overflow_o    sticky: at least one block was dropped since reset
//   idle_o        FIFO empty and shifter idle
// -----------------------------------------------------------------------------
module gp_byte_serializer #(
  parameter int FIFO_DEPTH = 16,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_valid_i,
  input  logic [127:0]     blk_data_i,
  output logic [7:0]       byte_o,
  output logic             byte_valid_o,
  input  logic             byte_ready_i,
  output logic             byte_last_o,
  output logic [CNT_W-1:0] fifo_count_o,
  output logic             overflow_o,
  output logic             idle_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [127:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  state_t           state_reg;
  logic [127:0]     shreg_reg;
  logic [3:0]       idx_reg;
  logic             byte_valid_reg;
  logic             byte_last_reg;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic             fifo_empty;
  logic             fifo_full;
  logic             handshake;
  logic             block_done;
  logic             pop;
  logic             push;
  logic             drop;
  logic [CNT_W-1:0] count_next;
  logic [127:0]     head_data;

  always_comb begin
    fifo_empty = (count_reg == '0);
    fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    handshake  = (state_reg == ST_SEND) && byte_ready_i;
    block_done = handshake && (idx_reg == 4'd15);

    // A pop happens when the shifter is idle, or when the last byte of the
    // current block is accepted. The second case reloads the shifter on the
    // same edge, so consecutive blocks leave without a bubble.
    pop = !fifo_empty && ((state_reg == ST_IDLE) || block_done);

    // A pop on the same edge frees the head slot. A full FIFO can therefore
    // still take the incoming block: the write lands in the slot that the
    // read pointer is leaving, because wr_ptr == rd_ptr when the FIFO is full.
    push = blk_valid_i && (!fifo_full || pop);
    drop = blk_valid_i && fifo_full && !pop;

    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end

    // Asynchronous read of the head entry. The FIFO has no bypass, so a block
    // written at edge N is first visible here after that edge and is popped
    // at edge N+1.
    head_data = mem[rd_ptr_reg];
  end

  // ---------------------------------------------------------------------------
  // FIFO storage (no reset: the contents are qualified by the pointers/count)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= blk_data_i;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy and loss flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);  // wraps naturally: depth is 2**AW
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shifter FSM
  //   ST_IDLE : wait for a block in the FIFO.
  //   ST_SEND : present shreg[127:120]; shift on every accepted byte.
  // byte_valid/byte_last are kept as registers alongside the state. Without a
  // handshake nothing in this block changes, so the presented byte is stable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      shreg_reg      <= '0;
      idx_reg        <= '0;
      byte_valid_reg <= 1'b0;
      byte_last_reg  <= 1'b0;
    end else begin
      if (pop) begin
        // Covers both the initial load from ST_IDLE and the back-to-back
        // reload on the final byte of the previous block.
        state_reg      <= ST_SEND;
        shreg_reg      <= head_data;
        idx_reg        <= '0;
        byte_valid_reg <= 1'b1;
        byte_last_reg  <= 1'b0;
      end else if (handshake) begin
        if (idx_reg == 4'd15) begin
          state_reg      <= ST_IDLE;
          shreg_reg      <= '0;
          idx_reg        <= '0;
          byte_valid_reg <= 1'b0;
          byte_last_reg  <= 1'b0;
        end else begin
          shreg_reg     <= {shreg_reg[119:0], 8'h00};
          idx_reg       <= idx_reg + 4'd1;
          byte_last_reg <= (idx_reg == 4'd14);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all derived directly from registers)
  // ---------------------------------------------------------------------------
  assign byte_o       = shreg_reg[127:120];
  assign byte_valid_o = byte_valid_reg;
  assign byte_last_o  = byte_last_reg;
  assign fifo_count_o = count_reg;
  assign overflow_o   = overflow_reg;
  assign idle_o       = (count_reg == '0) && (state_reg == ST_IDLE);

endmodule

// File: tb/tb_gp_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_gp_byte_serializer
//
// Purpose:
//   Self-checking bench for gp_byte_serializer.
//
// Structure:
//   - Two instances are used: dut A with FIFO_DEPTH=16 and dut B with
//     FIFO_DEPTH=4.
//   - Each stimulus task pushes the expected {last, byte} pairs into a
//     per-instance queue.
//   - A monitor per instance pops one pair and compares it on every accepted
//     byte.
//   - The monitor also checks that a stalled byte stays stable.
// -----------------------------------------------------------------------------
module tb_gp_byte_serializer;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // DUT A (depth 16)
  // ---------------------------------------------------------------------------
  logic         a_reset = 1'b0;
  logic         a_blk_valid = 1'b0;
  logic [127:0] a_blk_data = '0;
  logic [7:0]   a_byte;
  logic         a_valid;
  logic         a_ready_main = 1'b0;
  logic         a_ready_rnd = 1'b0;
  logic         a_rand = 1'b0;
  logic         a_ready;
  logic         a_last;
  logic [4:0]   a_count;
  logic         a_ovf;
  logic         a_idle;

  assign a_ready = a_rand ? a_ready_rnd : a_ready_main;

  gp_byte_serializer #(.FIFO_DEPTH(16)) u_dut_a (
    .clk          (clk),
    .reset        (a_reset),
    .blk_valid_i  (a_blk_valid),
    .blk_data_i   (a_blk_data),
    .byte_o       (a_byte),
    .byte_valid_o (a_valid),
    .byte_ready_i (a_ready),
    .byte_last_o  (a_last),
    .fifo_count_o (a_count),
    .overflow_o   (a_ovf),
    .idle_o       (a_idle)
  );

  // ---------------------------------------------------------------------------
  // DUT B (depth 4)
  // ---------------------------------------------------------------------------
  logic         b_reset = 1'b0;
  logic         b_blk_valid = 1'b0;
  logic [127:0] b_blk_data = '0;
  logic [7:0]   b_byte;
  logic         b_valid;
  logic         b_ready = 1'b0;
  logic         b_last;
  logic [2:0]   b_count;
  logic         b_ovf;
  logic         b_idle;

  gp_byte_serializer #(.FIFO_DEPTH(4)) u_dut_b (
    .clk          (clk),
    .reset        (b_reset),
    .blk_valid_i  (b_blk_valid),
    .blk_data_i   (b_blk_data),
    .byte_o       (b_byte),
    .byte_valid_o (b_valid),
    .byte_ready_i (b_ready),
    .byte_last_o  (b_last),
    .fifo_count_o (b_count),
    .overflow_o   (b_ovf),
    .idle_o       (b_idle)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [8:0] a_q[$];  // {last, byte}
  logic [8:0] b_q[$];
  int a_hs       = 0;
  int a_first_hs = -1;
  int a_last_hs  = -1;
  int a_peak     = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int which, input logic [127:0] d);
    for (int i = 0; i < 16; i++) begin
      if (which == 0) a_q.push_back({(i == 15), d[127-8*i -: 8]});
      else            b_q.push_back({(i == 15), d[127-8*i -: 8]});
    end
  endtask

  // Drive one block for one cycle; call again immediately for back-to-back.
  task automatic send_a(input logic [127:0] d);
    a_blk_valid = 1'b1;
    a_blk_data  = d;
    push_exp(0, d);
    @(posedge clk); #1;
    a_blk_valid = 1'b0;
  endtask

  task automatic send_b(input logic [127:0] d, input logic kept);
    b_blk_valid = 1'b1;
    b_blk_data  = d;
    if (kept) push_exp(1, d);
    @(posedge clk); #1;
    b_blk_valid = 1'b0;
  endtask

  task automatic drain_a(input int budget, input string name);
    int n = 0;
    while (!(a_q.size() == 0 && a_idle === 1'b1) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {a_q.size() == 0, a_idle}, 2'b11);
  endtask

  task automatic drain_b(input int budget, input string name);
    int n = 0;
    while (!(b_q.size() == 0 && b_idle === 1'b1) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, {b_q.size() == 0, b_idle}, 2'b11);
  endtask

  // Random ready source for the backpressure test
  initial forever begin
    @(posedge clk); #1;
    a_ready_rnd = 1'($urandom_range(0, 1));
  end

  // ---------------------------------------------------------------------------
  // Monitor A
  // ---------------------------------------------------------------------------
  initial begin
    logic       hold = 1'b0;
    logic [7:0] hold_byte = '0;
    logic       hold_last = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!a_reset) begin
        hold = 1'b0;
      end else begin
        if (a_count > 5'(a_peak)) a_peak = int'(a_count);
        if (hold) begin
          chk("a_stall_valid", a_valid, 1'b1);
          chk("a_stall_byte", a_byte, hold_byte);
          chk("a_stall_last", a_last, hold_last);
        end
        if (a_valid && a_ready) begin
          a_hs++;
          if (a_first_hs < 0) a_first_hs = cyc;
          a_last_hs = cyc;
          if (a_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_byte actual=%0h required=none", a_byte);
          end else begin
            e = a_q.pop_front();
            chk("a_byte", a_byte, e[7:0]);
            chk("a_last", a_last, e[8]);
          end
        end
        hold      = a_valid && !a_ready;
        hold_byte = a_byte;
        hold_last = a_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor B
  // ---------------------------------------------------------------------------
  initial begin
    logic       hold = 1'b0;
    logic [7:0] hold_byte = '0;
    logic       hold_last = 1'b0;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (!b_reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("b_stall_valid", b_valid, 1'b1);
          chk("b_stall_byte", b_byte, hold_byte);
          chk("b_stall_last", b_last, hold_last);
        end
        if (b_valid && b_ready) begin
          if (b_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_byte actual=%0h required=none", b_byte);
          end else begin
            e = b_q.pop_front();
            chk("b_byte", b_byte, e[7:0]);
            chk("b_last", b_last, e[8]);
          end
        end
        hold      = b_valid && !b_ready;
        hold_byte = b_byte;
        hold_last = b_last;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [127:0] BLK_S = 128'h1122334455667700ffeeddccbbaa9988;
  localparam logic [127:0] BLK_X = 128'hdeadbeef0123456789abcdeffedcba98;

  logic [127:0] burst [11];
  int w_cyc;

  initial begin
    burst[0]  = 128'hc177d2d3a4b5c6d7e8f9011223344556;
    burst[1]  = 128'h1b877faf00112233445566778899aabb;
    burst[2]  = 128'h2c3d4e5f60718293a4b5c6d7e8f90a1b;
    burst[3]  = 128'h3a3b3c3d3e3f40414243444546474849;
    burst[4]  = 128'h4f4e4d4c4b4a49484746454443424140;
    burst[5]  = 128'h5a5a5a5aa5a5a5a50f0f0f0ff0f0f0f0;
    burst[6]  = 128'h6677889900aabbccddeeff0102030405;
    burst[7]  = 128'h7e7d7c7b7a7978777675747372717069;
    burst[8]  = 128'h808182838485868788898a8b8c8d8e8f;
    burst[9]  = 128'h9f9e9d9c9b9a99989796959493929190;
    burst[10] = 128'haaaabbbbccccddddeeeeffff00001111;

    repeat (3) @(posedge clk);
    #1;

    // ---- Reset values ----
    chk("rst_byte", a_byte, 8'h00);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_last", a_last, 1'b0);
    chk("rst_count", a_count, 5'd0);
    chk("rst_ovf", a_ovf, 1'b0);
    chk("rst_idle", a_idle, 1'b1);
    a_reset = 1'b1;
    b_reset = 1'b1;
    @(posedge clk); #1;

    // ---- Test 1: reset mid-stream ----
    a_ready_main = 1'b1;
    send_a(BLK_X);
    repeat (5) @(posedge clk);
    #1;
    a_reset = 1'b0;
    a_q.delete();
    #1;
    chk("midrst_byte", a_byte, 8'h00);
    chk("midrst_valid", a_valid, 1'b0);
    chk("midrst_last", a_last, 1'b0);
    chk("midrst_count", a_count, 5'd0);
    chk("midrst_ovf", a_ovf, 1'b0);
    chk("midrst_idle", a_idle, 1'b1);
    @(posedge clk); #1;
    a_reset = 1'b1;
    @(posedge clk); #1;
    send_a(BLK_X);  // must restart from byte 0xde
    drain_a(200, "t1_drain");

    // ---- Test 2: single block, ready=1, latency and no gaps ----
    a_first_hs = -1;
    a_hs = 0;
    a_blk_valid = 1'b1;
    a_blk_data  = BLK_S;
    push_exp(0, BLK_S);
    @(posedge clk); #1;
    w_cyc = cyc;
    a_blk_valid = 1'b0;
    chk("t2_idle_busy", a_idle, 1'b0);
    drain_a(200, "t2_drain");
    chk("t2_latency", 32'(a_first_hs - w_cyc), 32'd1);
    chk("t2_span", 32'(a_last_hs - a_first_hs), 32'd15);
    chk("t2_count_hs", 32'(a_hs), 32'd16);

    // ---- Test 3: random backpressure ----
    a_hs = 0;
    a_rand = 1'b1;
    send_a(BLK_S);
    drain_a(400, "t3_drain");
    a_rand = 1'b0;
    chk("t3_count_hs", 32'(a_hs), 32'd16);

    // ---- Test 4: burst of 11 back-to-back blocks ----
    // First block popped one edge after its write. The next pop only happens
    // on the 16th accepted byte. So blocks 2..11 all sit in the FIFO: peak 10.
    a_first_hs = -1;
    a_hs = 0;
    a_peak = 0;
    for (int i = 0; i < 11; i++) send_a(burst[i]);
    drain_a(400, "t4_drain");
    chk("t4_span", 32'(a_last_hs - a_first_hs), 32'd175);
    chk("t4_count_hs", 32'(a_hs), 32'd176);
    chk("t4_ovf", a_ovf, 1'b0);
    chk("t4_peak", 32'(a_peak), 32'd10);

    // ---- Test 5: overflow on depth-4 instance ----
    b_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_b(burst[i], i < 5);
    chk("t5_count", b_count, 3'd4);
    chk("t5_ovf", b_ovf, 1'b1);
    chk("t5_valid", b_valid, 1'b1);
    chk("t5_head_byte", b_byte, 8'hc1);
    b_ready = 1'b1;
    drain_b(400, "t5_drain");
    chk("t5_ovf_sticky", b_ovf, 1'b1);

    // ---- Test 6: full FIFO, write coincides with last-byte pop ----
    b_reset = 1'b0;
    b_q.delete();
    b_ready = 1'b0;
    @(posedge clk); #1;
    b_reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) send_b(burst[i], 1'b1);
    chk("t6_full", b_count, 3'd4);
    b_ready = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    b_ready = 1'b0;
    chk("t6_at_last", b_last, 1'b1);
    chk("t6_full_hold", b_count, 3'd4);
    b_ready = 1'b1;
    send_b(burst[10], 1'b1);
    chk("t6_count_same", b_count, 3'd4);
    chk("t6_ovf", b_ovf, 1'b0);
    drain_b(400, "t6_drain");
    chk("t6_ovf_end", b_ovf, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
